// File: rtl/nios_setup_v2_nios2e_cpu_debug_slave_ocimem.sv
// Debug-slave OCI memory: JTAG debugger reads/writes and an Avalon-MM slave
// sharing one 2^ADDR_W x 32 single-port RAM, sequenced by a small FSM.
module nios_setup_v2_nios2e_cpu_debug_slave_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_error,
    output logic              monitor_ready,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JRD,
        S_JRD_CAP,
        S_JWR,
        S_AVRD,
        S_AVRD_DONE,
        S_AVWR
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_mon_d;
    logic [ADDR_W-1:0]   r_mon_a;
    logic                r_error;
    logic                r_jrd_pend;
    logic                r_jwr_pend;
    logic [31:0]         r_rd_hold;
    logic [31:0]         r_q;
    logic [31:0]         r_mem [DEPTH];

    logic                w_jtag_state;
    logic                w_busy;
    logic                w_overrun;
    logic                w_ld_acc;
    logic                w_inc_acc;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [3:0]          w_ram_we;
    logic [31:0]         w_ram_wdata;
    logic                w_unused_jdo;

    assign w_unused_jdo = ^{jdo[37], jdo[2:0]};

    assign w_jtag_state = (r_state == S_JRD) || (r_state == S_JRD_CAP) || (r_state == S_JWR);
    assign w_busy       = r_jrd_pend || r_jwr_pend || w_jtag_state;
    // A strobe that lands while JTAG work is outstanding is dropped whole.
    assign w_overrun    = (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) && w_busy;
    assign w_ld_acc     = take_action_ocimem_a && !w_busy;
    assign w_inc_acc    = take_no_action_ocimem_a && !w_busy;
    assign w_rd_acc     = (w_ld_acc && jdo[35]) || w_inc_acc;
    assign w_wr_acc     = take_action_ocimem_b && !w_busy;

    // Registered pends and Avalon outrank a strobe arriving this very cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_jwr_pend)      w_state_next = S_JWR;
                else if (r_jrd_pend) w_state_next = S_JRD;
                else if (avs_write)  w_state_next = S_AVWR;
                else if (avs_read)   w_state_next = S_AVRD;
                else if (w_wr_acc)   w_state_next = S_JWR;
                else if (w_rd_acc)   w_state_next = S_JRD;
            end
            S_JRD:   w_state_next = S_JRD_CAP;
            S_AVRD:  w_state_next = S_AVRD_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_mon_d    <= '0;
            r_mon_a    <= '0;
            r_error    <= 1'b0;
            r_jrd_pend <= 1'b0;
            r_jwr_pend <= 1'b0;
            r_rd_hold  <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_overrun)
                r_error <= 1'b1;
            else if (w_ld_acc && jdo[36])
                r_error <= 1'b0;

            if (w_ld_acc)
                r_mon_a <= jdo[26 +: ADDR_W];
            else if (w_inc_acc || r_state == S_JWR)
                r_mon_a <= r_mon_a + 1'b1;

            if (w_wr_acc)
                r_mon_d <= jdo[34:3];
            else if (r_state == S_JRD_CAP)
                r_mon_d <= r_q;

            if (w_rd_acc)
                r_jrd_pend <= 1'b1;
            else if (r_state == S_JRD_CAP)
                r_jrd_pend <= 1'b0;

            if (w_wr_acc)
                r_jwr_pend <= 1'b1;
            else if (r_state == S_JWR)
                r_jwr_pend <= 1'b0;

            if (r_state == S_AVRD_DONE)
                r_rd_hold <= r_q;
        end
    end

    assign w_ram_addr  = (r_state == S_AVRD || r_state == S_AVWR) ? avs_address : r_mon_a;
    assign w_ram_we    = (r_state == S_JWR)  ? 4'hF :
                         (r_state == S_AVWR) ? avs_byteenable : 4'h0;
    assign w_ram_wdata = (r_state == S_AVWR) ? avs_writedata : r_mon_d;

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we[i])
                r_mem[w_ram_addr][i*8 +: 8] <= w_ram_wdata[i*8 +: 8];
        end
        r_q <= r_mem[w_ram_addr];
    end

    assign MonDReg         = r_mon_d;
    assign MonAReg         = r_mon_a;
    assign monitor_error   = r_error;
    assign monitor_ready   = !w_busy;
    assign avs_waitrequest = !(r_state == S_AVRD_DONE || r_state == S_AVWR);
    // Read data is presented straight from the RAM in the completing cycle.
    assign avs_readdata    = (r_state == S_AVRD_DONE) ? r_q : r_rd_hold;

endmodule

// File: doc/nios_setup_v2_nios2e_cpu_debug_slave_ocimem.md
# nios_setup_v2_nios2e_cpu_debug_slave_ocimem

System-clock stage directly downstream of the debug-slave JTAG bridge. It consumes the `jdo` payload and `take_*_ocimem_*` strobes, and executes JTAG debugger reads and writes against a 256x32 on-chip debug RAM. The same RAM is shared with an Avalon-MM slave port used by the CPU. Results return to the JTAG side on `MonDReg`, and error status returns on `monitor_error`.

## Interface
- `ADDR_W`, 8: word-address width; RAM depth is 2^ADDR_W.
- `clk` input 1: system clock. All logic is in this single clock domain.
- `reset_n` input 1: asynchronous, active-low reset.
- `jdo` input 38: JTAG data, valid in the strobe cycle.
- `take_action_ocimem_a` input 1: address-load command strobe.
- `take_no_action_ocimem_a` input 1: auto-increment read strobe.
- `take_action_ocimem_b` input 1: write strobe.
- `MonDReg` output 32: JTAG read-data / write-data register.
- `MonAReg` output ADDR_W: current JTAG word address.
- `monitor_error` output 1: sticky overrun flag.
- `monitor_ready` output 1: high when no JTAG operation is pending or executing.
- `avs_address` input ADDR_W: Avalon word address.
- `avs_read` input 1: Avalon read request.
- `avs_write` input 1: Avalon write request.
- `avs_writedata` input 32: Avalon write data.
- `avs_byteenable` input 4: Avalon byte enables.
- `avs_readdata` output 32: Avalon read data.
- `avs_waitrequest` output 1: Avalon stall.

## Operation
- JTAG commands (single-cycle strobes, at most one per cycle):
  - `take_action_ocimem_a`: `MonAReg` <= `jdo[33:26]`. If `jdo[35]`=1, set `jrd_pend`. If `jdo[36]`=1, clear `monitor_error`.
  - `take_no_action_ocimem_a`: `MonAReg` <= `MonAReg`+1, wrapping 255->0. Set `jrd_pend`.
  - `take_action_ocimem_b`: `MonDReg` <= `jdo[34:3]`. Set `jwr_pend`.
- Overrun: if any strobe arrives while `jrd_pend`, `jwr_pend` or a JTAG state is active, the strobe is ignored entirely (no register change) and `monitor_error` is set. The error-clear bit is ignored in that case too.
- RAM: single-port, synchronous, 1-cycle read latency, per-byte write enables.
- FSM states:
  - IDLE
  - JRD: RAM read issued at `MonAReg`
  - JRD_CAP: `MonDReg` <= RAM q; clear `jrd_pend`
  - JWR: write `MonDReg` to `MonAReg` with all bytes enabled; clear `jwr_pend`; then `MonAReg` <= `MonAReg`+1
  - AVRD: RAM read issued at `avs_address`
  - AVRD_DONE: `avs_readdata` <= q; waitrequest low
  - AVWR: masked write; waitrequest low
- Arbitration in IDLE, highest priority first: `jwr_pend`, `jrd_pend`, `avs_write`, `avs_read`.
  - An Avalon transfer already past IDLE always completes before any JTAG work.
  - `avs_read` and `avs_write` both high is illegal; treat it as a write.
- All non-IDLE states return to IDLE after one cycle, except JRD -> JRD_CAP and AVRD -> AVRD_DONE.
- `monitor_ready` = !`jrd_pend` & !`jwr_pend` & (state not in {JRD, JRD_CAP, JWR}).

## Timing
- Reset values: `MonDReg`=0, `MonAReg`=0, `monitor_error`=0, `monitor_ready`=1, `avs_readdata`=0, `avs_waitrequest`=1, state=IDLE, pend flags=0.
- `avs_waitrequest` is low only in AVRD_DONE and AVWR, and high in every other cycle, including when idle.
  - Avalon write with FSM idle: request cycle 0, waitrequest low in cycle 1.
  - Avalon read with FSM idle: waitrequest low in cycle 2, with `avs_readdata` valid in that same cycle.
- JTAG read: strobe in cycle 0, pend visible in cycle 1. With the FSM idle, JRD is cycle 1, JRD_CAP is cycle 2, and `MonDReg` is updated and `monitor_ready` high from cycle 3.
- JTAG write: strobe in cycle 0, JWR in cycle 1, and `MonAReg` incremented from cycle 2.
- A strobe in the same cycle the FSM leaves IDLE for Avalon is captured as pending and serviced after that transfer.
- Reset mid-operation: all state returns to reset values immediately. Pending requests are lost, and RAM contents are not cleared.

## Test plan
- JTAG write then read: load address 0x10, write 0xDEADBEEF, load 0x10 with read bit -> `MonDReg`=0xDEADBEEF and `MonAReg`=0x11 after the write.
- Auto-increment wrap: address 0xFF, then `take_no_action_ocimem_a` -> reads word 0x00 and `MonAReg`=0x00.
- Avalon byteenable: RAM word 0x11223344, write 0xAABBCCDD with be=4'b0101 -> readback 0x11BB33DD; waitrequest low exactly on cycle 1 (write) and cycle 2 (read).
- Contention: `avs_read` and JTAG write strobe in the same cycle with the FSM idle -> Avalon read completes first, then JWR executes. Readdata shows the old value.
- Overrun: issue a read strobe, then a write strobe in the next cycle -> `monitor_error`=1 and `MonDReg` unchanged by the write. A later `take_action_ocimem_a` with `jdo[36]`=1 clears the error.
- Reset during JRD: assert `reset_n`=0 -> all outputs return to reset values immediately, with `monitor_ready`=1 and `avs_waitrequest`=1.
